// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - load-use and structural hazard scheduler with load-latency scoreboard
module hazard_scheduler #(
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  ixu1_id_rs1,
  input  logic [4:0]  ixu1_id_rs2,
  input  logic [4:0]  ixu2_id_rs1,
  input  logic [4:0]  ixu2_id_rs2,
  input  logic [4:0]  lsu_id_rs1,
  input  logic [4:0]  lsu_id_rs2,
  input  logic [4:0]  branch_id_rs1,
  input  logic [4:0]  branch_id_rs2,
  input  logic        lsu_id_is_load,
  input  logic [4:0]  lsu_id_rd,
  input  logic        mem_busy,
  input  logic        flush,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        issue_fire,
  output logic [1:0]  sched_state,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] STALL_LU = 2'd1;
  localparam logic [1:0] STALL_ST = 2'd2;
  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);

  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [2:0]  lat_cnt;
  logic [1:0]  state_q;
  logic [15:0] stall_cnt_q;

  logic src_match;
  logic lu_hazard;
  logic st_hazard;
  logic stall;
  logic load_fire;

  assign src_match = (ixu1_id_rs1 == pend_rd) | (ixu1_id_rs2 == pend_rd) |
                     (ixu2_id_rs1 == pend_rd) | (ixu2_id_rs2 == pend_rd) |
                     (lsu_id_rs1 == pend_rd)  | (lsu_id_rs2 == pend_rd)  |
                     (branch_id_rs1 == pend_rd) | (branch_id_rs2 == pend_rd);

  assign lu_hazard  = issue_valid & pend_valid & (pend_rd != 5'd0) & src_match;
  assign st_hazard  = issue_valid & pend_valid & lsu_id_is_load;
  assign stall      = (lu_hazard | st_hazard) & ~flush;
  assign issue_fire = issue_valid & ~stall & ~flush;
  assign load_fire  = issue_fire & lsu_id_is_load & (lsu_id_rd != 5'd0);

  assign stall_if     = stall;
  assign stall_id     = stall;
  assign bubble_ex    = stall;
  assign sched_state  = state_q;
  assign stall_cycles = stall_cnt_q;

  // A newly fired load overrides any countdown expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rd    <= 5'd0;
      lat_cnt    <= 3'd0;
    end else if (load_fire) begin
      pend_valid <= 1'b1;
      pend_rd    <= lsu_id_rd;
      lat_cnt    <= LAT_INIT;
    end else if (pend_valid && !mem_busy) begin
      lat_cnt <= lat_cnt - 3'd1;
      if (lat_cnt == 3'd1) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      if (lu_hazard && !flush) begin
        state_q <= STALL_LU;
      end else if (st_hazard && !flush) begin
        state_q <= STALL_ST;
      end else begin
        state_q <= RUN;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed and randomized bench for hazard_scheduler
module tb_hazard_scheduler;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  ixu1_id_rs1 = '0, ixu1_id_rs2 = '0, ixu2_id_rs1 = '0, ixu2_id_rs2 = '0;
  logic [4:0]  lsu_id_rs1 = '0, lsu_id_rs2 = '0, branch_id_rs1 = '0, branch_id_rs2 = '0;
  logic        lsu_id_is_load = 1'b0;
  logic [4:0]  lsu_id_rd = '0;
  logic        mem_busy = 1'b0;
  logic        flush = 1'b0;
  logic        stall_if, stall_id, bubble_ex, issue_fire;
  logic [1:0]  sched_state;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scheduler #(.LOAD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .ixu1_id_rs1(ixu1_id_rs1), .ixu1_id_rs2(ixu1_id_rs2),
    .ixu2_id_rs1(ixu2_id_rs1), .ixu2_id_rs2(ixu2_id_rs2),
    .lsu_id_rs1(lsu_id_rs1), .lsu_id_rs2(lsu_id_rs2),
    .branch_id_rs1(branch_id_rs1), .branch_id_rs2(branch_id_rs2),
    .lsu_id_is_load(lsu_id_is_load), .lsu_id_rd(lsu_id_rd),
    .mem_busy(mem_busy), .flush(flush),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .issue_fire(issue_fire), .sched_state(sched_state), .stall_cycles(stall_cycles)
  );

  int passed = 0;
  int total  = 0;

  // Reference: an outstanding load and how many non-busy edges have elapsed since it issued.
  bit m_pend;
  int m_rd, m_done, m_state, m_cnt;
  logic last_stall, last_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit reads(input int r);
    return (r != 0) && (ixu1_id_rs1 == r || ixu1_id_rs2 == r || ixu2_id_rs1 == r ||
                        ixu2_id_rs2 == r || lsu_id_rs1 == r || lsu_id_rs2 == r ||
                        branch_id_rs1 == r || branch_id_rs2 == r);
  endfunction

  task automatic idle();
    issue_valid = 0; lsu_id_is_load = 0; lsu_id_rd = 0; mem_busy = 0; flush = 0;
    ixu1_id_rs1 = 0; ixu1_id_rs2 = 0; ixu2_id_rs1 = 0; ixu2_id_rs2 = 0;
    lsu_id_rs1 = 0; lsu_id_rs2 = 0; branch_id_rs1 = 0; branch_id_rs2 = 0;
  endtask

  task automatic load(input int rd);
    idle(); issue_valid = 1; lsu_id_is_load = 1; lsu_id_rd = 5'(rd);
  endtask

  task automatic use_reg(input int r);
    idle(); issue_valid = 1; ixu1_id_rs1 = 5'(r);
  endtask

  // Entered and left at posedge+1: check combinational outputs mid-cycle, then registered ones.
  task automatic cycle();
    bit lu, st, stl, fire;
    #4;
    lu   = issue_valid && m_pend && reads(m_rd);
    st   = issue_valid && m_pend && lsu_id_is_load;
    stl  = (lu || st) && !flush;
    fire = issue_valid && !stl && !flush;
    chk("stall_if", 32'(stall_if), 32'(stl));
    chk("stall_id", 32'(stall_id), 32'(stl));
    chk("bubble_ex", 32'(bubble_ex), 32'(stl));
    chk("issue_fire", 32'(issue_fire), 32'(fire));
    last_stall = stall_if;
    last_fire  = issue_fire;
    if (fire && lsu_id_is_load && lsu_id_rd != 0) begin
      m_pend = 1; m_rd = int'(lsu_id_rd); m_done = 0;
    end else if (m_pend && !mem_busy) begin
      m_done++;
      if (m_done >= LAT) m_pend = 0;
    end
    m_state = flush ? 0 : lu ? 1 : st ? 2 : 0;
    if (stl && m_cnt < 65535) m_cnt++;
    @(posedge clk); #1;
    chk("sched_state", 32'(sched_state), 32'(m_state));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst_stall", 32'({stall_if, stall_id, bubble_ex, issue_fire}), 32'd0);
    chk("rst_state", 32'(sched_state), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    m_pend = 0; m_rd = 0; m_done = 0; m_state = 0; m_cnt = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    cycle();

    // Load-use: load x5 at c0, dependent from c1
    load(5); cycle();
    use_reg(5);
    cycle(); chk("lu_c1_stall", 32'(last_stall), 32'd1); chk("lu_c1_state", 32'(sched_state), 32'd1);
    cycle(); chk("lu_c2_stall", 32'(last_stall), 32'd1); chk("lu_c2_state", 32'(sched_state), 32'd1);
    cycle(); chk("lu_c3_fire", 32'(last_fire), 32'd1);
    chk("lu_cycles", 32'(stall_cycles), 32'd2);

    // x0 and non-matching sources never stall
    do_reset();
    load(0); cycle(); chk("x0_load_fire", 32'(last_fire), 32'd1);
    use_reg(0); cycle(); chk("x0_use_fire", 32'(last_fire), 32'd1);
    load(5); cycle();
    use_reg(6); cycle(); chk("x6_fire", 32'(last_fire), 32'd1);
    use_reg(0); cycle(); chk("x0_fire", 32'(last_fire), 32'd1);

    // mem_busy freezes the countdown
    do_reset();
    load(7); cycle();
    for (int c = 1; c <= 6; c++) begin
      idle(); issue_valid = 1; lsu_id_rs2 = 7; mem_busy = (c <= 3);
      cycle();
      chk("busy_stall", 32'(last_stall), (c <= 5) ? 32'd1 : 32'd0);
    end
    chk("busy_fire_c6", 32'(last_fire), 32'd1);

    // Structural: back-to-back loads
    do_reset();
    load(4); cycle();
    load(9);
    cycle(); chk("st_c1_state", 32'(sched_state), 32'd2);
    cycle(); chk("st_c2_state", 32'(sched_state), 32'd2);
    cycle(); chk("st_c3_fire", 32'(last_fire), 32'd1);

    // Flush during load-use stall keeps the scoreboard
    do_reset();
    load(5); cycle();
    use_reg(5); flush = 1; cycle();
    chk("fl_stall", 32'(last_stall), 32'd0); chk("fl_fire", 32'(last_fire), 32'd0);
    chk("fl_state", 32'(sched_state), 32'd0);
    use_reg(5); cycle(); chk("fl_pend_kept", 32'(last_stall), 32'd1);
    cycle(); chk("fl_after_fire", 32'(last_fire), 32'd1);

    // Reset mid-countdown abandons the load
    do_reset();
    load(5); cycle();
    use_reg(5); cycle();
    do_reset();
    idle(); cycle(); chk("post_rst_idle", 32'({stall_if, issue_fire}), 32'd0);
    use_reg(5); cycle();
    chk("post_rst_fire", 32'(last_fire), 32'd1); chk("post_rst_cnt", 32'(stall_cycles), 32'd0);

    // Randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 400; i++) begin
      issue_valid    = ($urandom_range(0, 9) < 8);
      ixu1_id_rs1    = 5'($urandom_range(0, 7)); ixu1_id_rs2 = 5'($urandom_range(0, 7));
      ixu2_id_rs1    = 5'($urandom_range(0, 15)); ixu2_id_rs2 = 5'($urandom_range(0, 15));
      lsu_id_rs1     = 5'($urandom_range(0, 15)); lsu_id_rs2 = 5'($urandom_range(0, 15));
      branch_id_rs1  = 5'($urandom_range(0, 31)); branch_id_rs2 = 5'($urandom_range(0, 31));
      lsu_id_is_load = ($urandom_range(0, 9) < 4);
      lsu_id_rd      = 5'($urandom_range(0, 7));
      mem_busy       = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Saturation: an endless load-use stall held by mem_busy
    do_reset();
    load(3); cycle();
    use_reg(3); mem_busy = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(stall_cycles), 32'hFFFF);
    chk("sat_still_stall", 32'(stall_if), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
